// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply-divide engine.
//
// Handshake: start is a request qualified only while busy==0. The engine has
// no ready/accept signal of its own; busy==0 in the cycle start is high means
// the request was taken. start while busy==1 is dropped without effect.
// done is a single-cycle pulse; hi/lo already hold the new result in that
// cycle. div_by_zero is only ever high together with done.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, mthi, mtlo,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, mthi, mtlo,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO register pair.
// One radix-2 step per cycle on unsigned magnitudes; signs are applied in a
// final FIXUP cycle, after which HI/LO are loaded and done pulses.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    mult_div_unit_if.slave      bus,
    output logic [1:0]          dbg_state_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             div_q;       // operation is a divide
    logic             neg_q;       // product / quotient must be negated
    logic             rem_neg_q;   // remainder must be negated (dividend sign)
    logic             dbz_pend_q;  // divide with a zero divisor
    logic [WIDTH-1:0] a_raw_q;     // dividend bits as issued, for divide-by-zero
    logic [WIDTH-1:0] opnd_q;      // addend (|a|) for multiply, divisor (|b|) for divide
    logic [WIDTH-1:0] acc_hi_q;    // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo_q;    // multiplier then product lower half / dividend then quotient
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             dbz_q;

    logic             a_neg_d;
    logic             b_neg_d;
    logic [WIDTH-1:0] mag_a_d;
    logic [WIDTH-1:0] mag_b_d;
    logic [WIDTH:0]   mul_sum_d;
    logic [WIDTH:0]   div_shift_d;
    logic [WIDTH:0]   div_diff_d;
    logic [WIDTH-1:0] acc_hi_d;
    logic [WIDTH-1:0] acc_lo_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0] fix_hi_d;
    logic [WIDTH-1:0] fix_lo_d;

    // Operand magnitudes for capture, one iteration step, and sign fix-up.
    always_comb begin
        a_neg_d   = ~bus.op[0] & bus.operand_a[WIDTH-1];
        b_neg_d   = ~bus.op[0] & bus.operand_b[WIDTH-1];
        mag_a_d   = a_neg_d ? ({WIDTH{1'b0}} - bus.operand_a) : bus.operand_a;
        mag_b_d   = b_neg_d ? ({WIDTH{1'b0}} - bus.operand_b) : bus.operand_b;

        // Multiply: add |a| into the upper half when the current multiplier
        // bit is set, then shift the whole 2*WIDTH accumulator right by one.
        mul_sum_d = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

        // Divide: shift the next dividend bit into the remainder and try to
        // subtract the divisor; a borrow out of the top bit means restore.
        div_shift_d = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff_d  = div_shift_d - {1'b0, opnd_q};

        if (div_q) begin
            if (!div_diff_d[WIDTH]) begin
                acc_hi_d = div_diff_d[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_d = div_shift_d[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_hi_d = mul_sum_d[WIDTH:1];
            acc_lo_d = {mul_sum_d[0], acc_lo_q[WIDTH-1:1]};
        end

        prod_d = {acc_hi_q, acc_lo_q};
        if (neg_q) begin
            prod_d = {(2*WIDTH){1'b0}} - prod_d;
        end

        if (dbz_pend_q) begin
            fix_hi_d = a_raw_q;
            fix_lo_d = {WIDTH{1'b1}};
        end else if (div_q) begin
            fix_hi_d = rem_neg_q ? ({WIDTH{1'b0}} - acc_hi_q) : acc_hi_q;
            fix_lo_d = neg_q ? ({WIDTH{1'b0}} - acc_lo_q) : acc_lo_q;
        end else begin
            fix_hi_d = prod_d[2*WIDTH-1:WIDTH];
            fix_lo_d = prod_d[WIDTH-1:0];
        end
    end

    // Control FSM with registered HI/LO and result pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            a_raw_q    <= '0;
            opnd_q     <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        // start has priority; a coincident mthi/mtlo is dropped.
                        div_q      <= bus.op[1];
                        neg_q      <= a_neg_d ^ b_neg_d;
                        rem_neg_q  <= a_neg_d;
                        dbz_pend_q <= bus.op[1] & (bus.operand_b == '0);
                        a_raw_q    <= bus.operand_a;
                        opnd_q     <= bus.op[1] ? mag_b_d : mag_a_d;
                        acc_lo_q   <= bus.op[1] ? mag_a_d : mag_b_d;
                        acc_hi_q   <= '0;
                        cnt_q      <= '0;
                        state_q    <= CALC;
                    end else begin
                        if (bus.mthi) hi_q <= bus.operand_a;
                        if (bus.mtlo) lo_q <= bus.operand_a;
                    end
                end
                CALC: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIXUP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIXUP: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    done_q  <= 1'b1;
                    dbz_q   <= dbz_pend_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign dbg_state_o     = state_q;
endmodule
